// File: rtl/video_timing_meter.sv
// Measures line/frame geometry of a hs/vs/de video stream sampled on ce_pix.
// Results publish two clk_sys cycles after the VS rising sample, together with lock status.
module video_timing_meter #(
   parameter int CNT_W         = 12,
   parameter int STABLE_FRAMES = 2
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             ce_pix,
   input  logic             hs,
   input  logic             vs,
   input  logic             de,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] hs_width,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_active,
   output logic             frame_done,
   output logic             locked,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] MAX_CNT = '1;
   localparam logic [3:0]       STAB    = 4'(STABLE_FRAMES);

   // Returns {saturated, next}; the count holds at all-ones instead of wrapping
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == MAX_CNT) return {1'b1, v};
      return {1'b0, v + CNT_W'(1)};
   endfunction

   function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic             r_old_hs, r_old_vs, r_primed, r_ovf_pend;
   logic [CNT_W-1:0] r_h_cnt, r_line_len, r_hw_cnt, r_de_cnt, r_line_max, r_v_cnt, r_v_act_cnt;

   logic             r_vld_p0, r_ovf_p0, r_vld_p1, r_ovf_p1;
   logic [CNT_W-1:0] r_ht_p0, r_ha_p0, r_vt_p0, r_va_p0;
   logic [CNT_W-1:0] r_ht_p1, r_ha_p1, r_vt_p1, r_va_p1;
   logic [3:0]       r_match_cnt;

   logic             w_hs_rise, w_hs_fall, w_vs_rise, w_de_any, w_sat_now;
   logic [CNT_W:0]   w_h_inc, w_de_inc, w_hw_inc, w_v_inc, w_va_inc;
   logic [CNT_W-1:0] w_line_len_n, w_line_max_n, w_v_cnt_n, w_v_act_n;
   logic             w_same;
   logic [3:0]       w_match_inc;

   assign w_hs_rise = ce_pix & hs & ~r_old_hs;
   assign w_hs_fall = ce_pix & ~hs & r_old_hs;
   assign w_vs_rise = ce_pix & vs & ~r_old_vs;
   assign w_de_any  = (r_de_cnt != '0);

   assign w_h_inc  = sat_inc(r_h_cnt);
   assign w_de_inc = sat_inc(r_de_cnt);
   assign w_hw_inc = sat_inc(r_hw_cnt);
   assign w_v_inc  = sat_inc(r_v_cnt);
   assign w_va_inc = sat_inc(r_v_act_cnt);

   // Line-close results; the frame capture uses these so a coincident HS is already folded in
   assign w_line_len_n = w_hs_rise ? r_h_cnt : r_line_len;
   assign w_line_max_n = w_hs_rise ? umax(r_line_max, r_de_cnt) : r_line_max;
   assign w_v_cnt_n    = w_hs_rise ? w_v_inc[CNT_W-1:0] : r_v_cnt;
   assign w_v_act_n    = (w_hs_rise && w_de_any) ? w_va_inc[CNT_W-1:0] : r_v_act_cnt;

   assign w_sat_now = ce_pix & ((~w_hs_rise & w_h_inc[CNT_W]) |
                                (~w_hs_rise & de & w_de_inc[CNT_W]) |
                                (hs & w_hw_inc[CNT_W]) |
                                (w_hs_rise & w_v_inc[CNT_W]) |
                                (w_hs_rise & w_de_any & w_va_inc[CNT_W]));

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_old_hs    <= 1'b0;
         r_old_vs    <= 1'b0;
         r_primed    <= 1'b0;
         r_ovf_pend  <= 1'b0;
         r_h_cnt     <= '0;
         r_line_len  <= '0;
         r_hw_cnt    <= '0;
         r_de_cnt    <= '0;
         r_line_max  <= '0;
         r_v_cnt     <= '0;
         r_v_act_cnt <= '0;
         hs_width    <= '0;
      end else if (ce_pix) begin
         r_old_hs   <= hs;
         r_old_vs   <= vs;
         r_h_cnt    <= w_hs_rise ? CNT_W'(1) : w_h_inc[CNT_W-1:0];
         r_line_len <= w_line_len_n;
         if (w_hs_rise)
            r_de_cnt <= de ? CNT_W'(1) : '0;
         else if (de)
            r_de_cnt <= w_de_inc[CNT_W-1:0];
         if (w_hs_fall) begin
            hs_width <= r_hw_cnt;
            r_hw_cnt <= '0;
         end else if (hs) begin
            r_hw_cnt <= w_hw_inc[CNT_W-1:0];
         end
         if (w_vs_rise) begin
            r_v_cnt     <= '0;
            r_v_act_cnt <= '0;
            r_line_max  <= '0;
            r_ovf_pend  <= 1'b0;
            r_primed    <= 1'b1;
         end else begin
            r_v_cnt     <= w_v_cnt_n;
            r_v_act_cnt <= w_v_act_n;
            r_line_max  <= w_line_max_n;
            r_ovf_pend  <= r_ovf_pend | w_sat_now;
         end
      end
   end

   assign w_same      = ({r_ht_p1, r_ha_p1, r_vt_p1, r_va_p1} == {h_total, h_active, v_total, v_active});
   assign w_match_inc = (r_match_cnt >= STAB) ? STAB : r_match_cnt + 4'd1;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_vld_p0    <= 1'b0;
         r_ovf_p0    <= 1'b0;
         r_ht_p0     <= '0;
         r_ha_p0     <= '0;
         r_vt_p0     <= '0;
         r_va_p0     <= '0;
         r_vld_p1    <= 1'b0;
         r_ovf_p1    <= 1'b0;
         r_ht_p1     <= '0;
         r_ha_p1     <= '0;
         r_vt_p1     <= '0;
         r_va_p1     <= '0;
         r_match_cnt <= '0;
         h_total     <= '0;
         h_active    <= '0;
         v_total     <= '0;
         v_active    <= '0;
         overflow    <= 1'b0;
         frame_done  <= 1'b0;
         locked      <= 1'b0;
      end else begin
         // Stage p0: freeze the closing frame on the VS rising sample
         r_vld_p0 <= w_vs_rise & r_primed;
         if (w_vs_rise) begin
            r_ht_p0  <= w_line_len_n;
            r_ha_p0  <= w_line_max_n;
            r_vt_p0  <= w_v_cnt_n;
            r_va_p0  <= w_v_act_n;
            r_ovf_p0 <= r_ovf_pend | w_sat_now;
         end
         // Stage p1
         r_vld_p1 <= r_vld_p0;
         r_ht_p1  <= r_ht_p0;
         r_ha_p1  <= r_ha_p0;
         r_vt_p1  <= r_vt_p0;
         r_va_p1  <= r_va_p0;
         r_ovf_p1 <= r_ovf_p0;
         // Stage p2: publish; outputs still hold the previous capture for the lock compare
         frame_done <= r_vld_p1;
         if (r_vld_p1) begin
            h_total  <= r_ht_p1;
            h_active <= r_ha_p1;
            v_total  <= r_vt_p1;
            v_active <= r_va_p1;
            overflow <= r_ovf_p1;
            if (w_same && !r_ovf_p1) begin
               r_match_cnt <= w_match_inc;
               locked      <= (w_match_inc >= STAB - 4'd1);
            end else begin
               r_match_cnt <= '0;
               locked      <= (STAB == 4'd1) && !r_ovf_p1;
            end
         end
      end
   end

endmodule
